fifo_serial_tx: RTL and testbench

FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

---
 rtl/fifo_serial_tx.sv | 145 ++++++++++++++
 tb/tb_fifo_serial_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_tx.sv
// FIFO-fed serial transmitter: fetches one byte per frame and sends start, 8 data bits LSB first, stop.
// Define FIFO_SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_serial_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    input  logic       tx_enable,
    output logic       fifo_read_n,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] debug_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef FIFO_SERIAL_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } state_t;

    localparam logic [15:0] LAST_CNT     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] PRE_LAST_CNT = 16'(CLKS_PER_BIT - 2);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        bit_end;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic        parity_bit;
`endif

    assign bit_end     = (baud_cnt == LAST_CNT);
    assign debug_state = state;

    // Outputs are assigned together with the state transition so they line up with the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx          <= 1'b1;
            fifo_read_n <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            shift_reg   <= 8'd0;
            bit_cnt     <= 3'd0;
            baud_cnt    <= 16'd0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= 16'd0;
                    if (tx_enable && !fifo_empty) begin
                        state       <= FETCH;
                        fifo_read_n <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                FETCH: begin
                    state       <= LOAD;
                    fifo_read_n <= 1'b1;
                end
                LOAD: begin
                    shift_reg <= fifo_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                    parity_bit <= ^fifo_data;
`endif
                    bit_cnt   <= 3'd0;
                    baud_cnt  <= 16'd0;
                    state     <= START;
                    tx        <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        state    <= DATA;
                        tx       <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt  <= 16'd0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                            state   <= PARITY;
                            tx      <= parity_bit;
`else
                            state   <= STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`ifdef FIFO_SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    // frame_done is registered, so it is raised one count early to land on the last cycle.
                    if (bit_end) begin
                        baud_cnt <= 16'd0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                        if (baud_cnt == PRE_LAST_CNT) frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: table of single-byte frames plus back-to-back, enable-gating and reset sequences.
module tb_fifo_serial_tx;

    localparam int CPB = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int HIST = 8192;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] fifo_data = 8'd0;
    logic       fifo_empty = 1'b1;
    logic       tx_enable = 1'b0;
    logic       fifo_read_n;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [2:0] debug_state;

    fifo_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock       (clock),
        .reset       (reset),
        .fifo_data   (fifo_data),
        .fifo_empty  (fifo_empty),
        .tx_enable   (tx_enable),
        .fifo_read_n (fifo_read_n),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done),
        .debug_state (debug_state)
    );

    always #5 clock = ~clock;

    logic [7:0] fifo_q[$];
    int         start_q[$];
    logic       tx_hist[HIST];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         busy_cnt = 0;
    int         done_cnt = 0;
    int         rd_cnt = 0;
    int         done_cyc = -1;
    logic       armed = 1'b0;
    logic       tx_prev = 1'b1;
    vec_t       vecs[6];

    // FIFO model and line monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (cyc < HIST) tx_hist[cyc] = tx;
        if (busy === 1'b1) busy_cnt++;
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (fifo_read_n === 1'b0) begin
            rd_cnt++;
            armed = 1'b1;
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
        end
        if (armed && tx_prev === 1'b1 && tx === 1'b0) begin
            start_q.push_back(cyc);
            armed = 1'b0;
        end
        tx_prev = tx;
        cyc++;
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int t;
        t = 0;
        while ((done_cnt < target || busy === 1'b1) && t < budget) begin
            step();
            t++;
        end
        chk({name, " timeout"}, 32'(t < budget), 1);
    endtask

    task automatic wait_start(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (start_q.size() <= n && t < budget) begin
            step();
            t++;
        end
        chk({name, " start timeout"}, 32'(t < budget), 1);
    endtask

    task automatic check_bits(input int s, input logic [10:0] exp, input string name);
        logic ok;
        for (int k = 0; k < NBITS; k++) begin
            ok = 1'b1;
            for (int j = 0; j < CPB; j++) begin
                if (s + k * CPB + j >= HIST || tx_hist[s + k * CPB + j] !== exp[k]) ok = 1'b0;
            end
            chk($sformatf("%s bit%0d", name, k), 32'(ok), 1);
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [10:0] exp, input string name);
        int b0, d0, r0, n0;
        b0 = busy_cnt;
        d0 = done_cnt;
        r0 = rd_cnt;
        n0 = start_q.size();
        tx_enable = 1'b1;
        push(d);
        wait_done(d0 + 1, 400, name);
        chk({name, " read strobes"}, rd_cnt - r0, 1);
        chk({name, " frame_done pulses"}, done_cnt - d0, 1);
        chk({name, " busy cycles"}, busy_cnt - b0, 2 + NBITS * CPB);
        chk({name, " start bits"}, start_q.size() - n0, 1);
        if (start_q.size() > n0) begin
            check_bits(start_q[n0], exp, name);
            chk({name, " frame_done position"}, done_cyc, start_q[n0] + NBITS * CPB - 1);
        end
    endtask

    initial begin
        int d0, r0, n0, s1, s2;
        logic ok;
        string nm;

        // bit k of exp is the k-th transmitted bit: {stop, [parity], data[7:0], start}
`ifdef FIFO_SERIAL_TX_PARITY_EN
        vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
        vecs[1] = '{8'h07, 11'b1_1_00000111_0};
        vecs[2] = '{8'h00, 11'b1_0_00000000_0};
        vecs[3] = '{8'hFF, 11'b1_0_11111111_0};
        vecs[4] = '{8'h80, 11'b1_1_10000000_0};
        vecs[5] = '{8'h01, 11'b1_1_00000001_0};
`else
        vecs[0] = '{8'hA5, 11'b0_1_10100101_0};
        vecs[1] = '{8'h07, 11'b0_1_00000111_0};
        vecs[2] = '{8'h00, 11'b0_1_00000000_0};
        vecs[3] = '{8'hFF, 11'b0_1_11111111_0};
        vecs[4] = '{8'h80, 11'b0_1_10000000_0};
        vecs[5] = '{8'h01, 11'b0_1_00000001_0};
`endif

        // reset state while reset is held
        #7;
        chk("reset tx", 32'(tx), 1);
        chk("reset fifo_read_n", 32'(fifo_read_n), 1);
        chk("reset busy", 32'(busy), 0);
        chk("reset frame_done", 32'(frame_done), 0);
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("idle tx", 32'(tx), 1);
        chk("idle no read", rd_cnt, 0);

        for (int i = 0; i < 6; i++) begin
            nm = $sformatf("frame_%02h", vecs[i].data);
            run_frame(vecs[i].data, vecs[i].exp, nm);
            repeat (5) step();
        end

        // back-to-back 0x00 then 0xFF
        d0 = done_cnt;
        r0 = rd_cnt;
        n0 = start_q.size();
        push(8'h00);
        push(8'hFF);
        wait_done(d0 + 2, 800, "b2b");
        chk("b2b read strobes", rd_cnt - r0, 2);
        chk("b2b frame_done pulses", done_cnt - d0, 2);
        chk("b2b start bits", start_q.size() - n0, 2);
        if (start_q.size() >= n0 + 2) begin
            s1 = start_q[n0];
            s2 = start_q[n0 + 1];
            chk("b2b start spacing", s2 - s1, 3 + NBITS * CPB);
            ok = 1'b1;
            for (int c = s1 + (NBITS - 1) * CPB; c < s2; c++) if (tx_hist[c] !== 1'b1) ok = 1'b0;
            chk("b2b tx high between frames", 32'(ok), 1);
            chk("b2b frame0 data bit", 32'(tx_hist[s1 + CPB + 1]), 0);
            chk("b2b frame1 data bit", 32'(tx_hist[s2 + CPB + 1]), 1);
        end
        repeat (5) step();

        // tx_enable dropped during DATA of 0x3C with another byte waiting
        d0 = done_cnt;
        r0 = rd_cnt;
        n0 = start_q.size();
        push(8'h3C);
        push(8'h55);
        wait_start(n0, 100, "gate");
        repeat (3 * CPB) step();
        tx_enable = 1'b0;
        wait_done(d0 + 1, 400, "gate");
        repeat (60) step();
        chk("gate frame_done pulses", done_cnt - d0, 1);
        chk("gate read strobes", rd_cnt - r0, 1);
        chk("gate fifo left", fifo_q.size(), 1);
        chk("gate busy", 32'(busy), 0);
        chk("gate tx idle", 32'(tx), 1);
`ifdef FIFO_SERIAL_TX_PARITY_EN
        if (start_q.size() > n0) check_bits(start_q[n0], 11'b1_0_00111100_0, "gate_3c");
`else
        if (start_q.size() > n0) check_bits(start_q[n0], 11'b0_1_00111100_0, "gate_3c");
`endif
        tx_enable = 1'b1;
        wait_done(d0 + 2, 400, "gate drain");
        chk("gate drain read strobes", rd_cnt - r0, 2);
        repeat (5) step();

        // reset pulsed during data bit 3 of 0x96, then 0x5A must start with a fresh fetch
        n0 = start_q.size();
        push(8'h96);
        push(8'h5A);
        wait_start(n0, 100, "rst");
        repeat (4 * CPB + 1) step();
        chk("rst tx before reset", 32'(tx), 0);
        #1 reset = 1'b1;
        #1;
        chk("rst async tx", 32'(tx), 1);
        chk("rst async fifo_read_n", 32'(fifo_read_n), 1);
        chk("rst async busy", 32'(busy), 0);
        chk("rst async frame_done", 32'(frame_done), 0);
        step();
        reset = 1'b0;
        r0 = rd_cnt;
        d0 = done_cnt;
        n0 = start_q.size();
        step();
        chk("rst first fetch", 32'(fifo_read_n), 0);
        wait_done(d0 + 1, 400, "rst");
        chk("rst read strobes", rd_cnt - r0, 1);
        chk("rst fifo empty", fifo_q.size(), 0);
`ifdef FIFO_SERIAL_TX_PARITY_EN
        if (start_q.size() > n0) check_bits(start_q[n0], 11'b1_0_01011010_0, "rst_5a");
`else
        if (start_q.size() > n0) check_bits(start_q[n0], 11'b0_1_01011010_0, "rst_5a");
`endif
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
